dmem_dump_arbiter: RTL and testbench

DMEM_DUMP_ARBITER -- requirements
Module: dmem_dump_arbiter

---
 rtl/dmem_dump_arbiter_pkg.sv | 19 +
 rtl/rr_arb2.sv | 43 ++++
 rtl/dmem_dump_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_dump_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_dump_arbiter_pkg.sv
// Shared types and constants for the data-memory dump arbiter.
package dmem_dump_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } dumpState_t;

  typedef enum logic {
    GNT_CPU,
    GNT_DUMP
  } gntOwner_t;

  localparam int NUM_ELE    = 5;
  localparam int ELE_STRIDE = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (CPU vs dump engine).
// A sole requester always wins; under contention the requester that was
// not granted most recently wins. The grant itself is combinational.
module rr_arb2
  import dmem_dump_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_reqCpu,
  input  logic i_reqDump,
  output logic o_gntCpu,
  output logic o_gntDump
);

  gntOwner_t r_lastGrant;
  logic      w_cpuWins;

  // Pick the winner for this cycle from the live requests and the history flop
  always_comb begin
    w_cpuWins = 1'b0;
    o_gntCpu  = 1'b0;
    o_gntDump = 1'b0;
    if (i_reqCpu && i_reqDump) begin
      w_cpuWins = (r_lastGrant == GNT_DUMP);
    end else begin
      w_cpuWins = i_reqCpu;
    end
    o_gntCpu  = i_reqCpu && w_cpuWins;
    o_gntDump = i_reqDump && !w_cpuWins;
  end

  // Remember who was served last; reset favours the CPU on first contention
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastGrant <= GNT_DUMP;
    end else if (o_gntCpu) begin
      r_lastGrant <= GNT_CPU;
    end else if (o_gntDump) begin
      r_lastGrant <= GNT_DUMP;
    end
  end

endmodule

// File: rtl/dmem_dump_arbiter.sv
// Shares one single-port data memory between the CPU and a dump engine
// that reads five array elements into output registers on request.
module dmem_dump_arbiter
  import dmem_dump_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int ELE_BASE = 0,
  parameter int NUM_ELE  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [63:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [63:0]       cpu_rdata,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [63:0]       ele1,
  output logic [63:0]       ele2,
  output logic [63:0]       ele3,
  output logic [63:0]       ele4,
  output logic [63:0]       ele5,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  localparam int IDX_W = 3;

  dumpState_t        r_state;
  dumpState_t        w_nextState;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_capTag;
  logic              r_capPending;
  logic              r_cpuRdPending;
  logic [63:0]       r_ele [NUM_ELE];
  logic              w_dumpReq;
  logic              w_cpuReq;
  logic              w_gntCpu;
  logic              w_gntDump;
  logic              w_lastIssue;
  logic              w_lastCapture;
  logic [ADDR_W-1:0] w_dumpAddr;

  // Requests are masked while reset is high so nothing reaches memory
  assign w_cpuReq      = cpu_req && !reset;
  assign w_dumpAddr    = ADDR_W'(ELE_BASE + ELE_STRIDE * int'(r_idx));
  assign w_lastIssue   = (r_idx == IDX_W'(NUM_ELE - 1));
  assign w_lastCapture = r_capPending && (r_capTag == IDX_W'(NUM_ELE - 1));

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_reqCpu  (w_cpuReq),
    .i_reqDump (w_dumpReq),
    .o_gntCpu  (w_gntCpu),
    .o_gntDump (w_gntDump)
  );

  // Dump FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Dump FSM next state: issue five reads, wait for the last one to land, pulse done
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (dump_start) w_nextState = ST_ISSUE;
      ST_ISSUE: if (w_gntDump && w_lastIssue) w_nextState = ST_DRAIN;
      ST_DRAIN: if (w_lastCapture) w_nextState = ST_DONE;
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Dump FSM outputs, forced quiet while reset is held
  always_comb begin
    w_dumpReq = 1'b0;
    dump_busy = 1'b0;
    dump_done = 1'b0;
    if (!reset) begin
      w_dumpReq = (r_state == ST_ISSUE);
      dump_busy = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
      dump_done = (r_state == ST_DONE);
    end
  end

  // Element index advances only when its read is granted; the tag follows the read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_capTag     <= '0;
      r_capPending <= 1'b0;
    end else begin
      r_capPending <= w_gntDump;
      if (w_gntDump) begin
        r_capTag <= r_idx;
        r_idx    <= w_lastIssue ? '0 : r_idx + 3'd1;
      end
    end
  end

  // Capture returning dump data; CPU traffic never touches these registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_ELE; k++) r_ele[k] <= '0;
    end else if (r_capPending) begin
      r_ele[r_capTag] <= mem_rdata;
    end
  end

  // Track a granted CPU read so its data is flagged valid the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpuRdPending <= 1'b0;
    end else begin
      r_cpuRdPending <= w_gntCpu && !cpu_we;
    end
  end

  assign cpu_stall  = cpu_req && !w_gntCpu;
  assign cpu_rvalid = r_cpuRdPending && !reset;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;

  assign mem_en    = w_gntCpu || w_gntDump;
  assign mem_we    = w_gntCpu && cpu_we;
  assign mem_addr  = w_gntCpu ? cpu_addr : (w_gntDump ? w_dumpAddr : '0);
  assign mem_wdata = w_gntCpu ? cpu_wdata : '0;

  assign ele1 = r_ele[0];
  assign ele2 = r_ele[1];
  assign ele3 = r_ele[2];
  assign ele4 = r_ele[3];
  assign ele5 = r_ele[4];

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Bench for dmem_dump_arbiter: a behavioural memory, a reference copy of
// memory contents, and a scoreboard that checks every CPU read return and
// every completed dump against expectations queued when they were issued.
module tb_dmem_dump_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        dump_start;
  logic        dump_busy;
  logic        dump_done;
  logic [63:0] ele1, ele2, ele3, ele4, ele5;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  logic [63:0]      memArr [128];
  logic [63:0]      refMem [128];
  logic [63:0]      expRd [$];
  logic [4:0][63:0] expDump [$];
  logic [4:0][63:0] monExp;

  dmem_dump_arbiter #(.ADDR_W(10), .ELE_BASE(0), .NUM_ELE(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .ele1       (ele1),
    .ele2       (ele2),
    .ele3       (ele3),
    .ele4       (ele4),
    .ele5       (ele5),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory with one-cycle synchronous read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) memArr[mem_addr[9:3]] <= mem_wdata;
      else        mem_rdata <= memArr[mem_addr[9:3]];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  // Monitor: every read return and every dump completion is matched to the queue
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_rvalid) begin
        if (expRd.size() == 0) checkOutput("rvalid_spurious", 64'(cpu_rvalid), 64'd0);
        else checkOutput("cpu_rdata", cpu_rdata, expRd.pop_front());
      end else begin
        checkOutput("cpu_rdata_idle_zero", cpu_rdata, 64'd0);
      end
      if (dump_done) begin
        if (expDump.size() == 0) begin
          checkOutput("done_spurious", 64'(dump_done), 64'd0);
        end else begin
          monExp = expDump.pop_front();
          checkOutput("dump_ele1", ele1, monExp[0]);
          checkOutput("dump_ele2", ele2, monExp[1]);
          checkOutput("dump_ele3", ele3, monExp[2]);
          checkOutput("dump_ele4", ele4, monExp[3]);
          checkOutput("dump_ele5", ele5, monExp[4]);
        end
      end
    end
  end

  function automatic logic [9:0] randAddr(input int lo);
    return 10'($urandom_range(lo, 127) * 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushDumpExpectation();
    logic [4:0][63:0] snap;
    for (int k = 0; k < 5; k++) snap[k] = refMem[k];
    expDump.push_back(snap);
  endtask

  // One CPU access, held until accepted (bounded)
  task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [63:0] wdata);
    logic accepted;
    accepted  = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int c = 0; c < 40 && !accepted; c++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        if (we) refMem[addr[9:3]] = wdata;
        else    expRd.push_back(refMem[addr[9:3]]);
        accepted = 1'b1;
      end
      tick();
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    if (!accepted) checkOutput("cpu_accept_timeout", 64'(accepted), 64'd1);
  endtask

  // Start a dump and report the cycle (relative to the start edge) carrying dump_done
  task automatic runDump(output int doneAt);
    pushDumpExpectation();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    doneAt = -1;
    for (int n = 1; n <= 40 && doneAt < 0; n++) begin
      @(negedge clk);
      if (dump_done) doneAt = n;
      tick();
    end
  endtask

  task automatic doReset();
    reset      = 1'b1;
    cpu_req    = 1'b1;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    dump_start = 1'b0;
    expRd.delete();
    expDump.delete();
    @(negedge clk);
    checkOutput("reset_mem_en", 64'(mem_en), 64'd0);
    checkOutput("reset_stall", 64'(cpu_stall), 64'd1);
    checkOutput("reset_busy", 64'(dump_busy), 64'd0);
    tick();
    tick();
    reset   = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_ele1", ele1, 64'd0);
    checkOutput("rst_ele2", ele2, 64'd0);
    checkOutput("rst_ele3", ele3, 64'd0);
    checkOutput("rst_ele4", ele4, 64'd0);
    checkOutput("rst_ele5", ele5, 64'd0);
    checkOutput("rst_done", 64'(dump_done), 64'd0);
    checkOutput("rst_rvalid", 64'(cpu_rvalid), 64'd0);
    tick();
  endtask

  task automatic drainCheck();
    repeat (3) tick();
    checkOutput("leftover_reads", 64'(expRd.size()), 64'd0);
    checkOutput("leftover_dumps", 64'(expDump.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneAt;
    int reads;
    int dones;
    logic got;

    for (int w = 0; w < 128; w++) begin
      memArr[w] = {$urandom, $urandom};
      refMem[w] = memArr[w];
    end
    reset = 1'b1;
    doReset();

    // Uncontended dump of 5,3,9,1,7
    memArr[0] = 64'd5; memArr[1] = 64'd3; memArr[2] = 64'd9; memArr[3] = 64'd1; memArr[4] = 64'd7;
    for (int w = 0; w < 5; w++) refMem[w] = memArr[w];
    runDump(doneAt);
    checkOutput("uncontended_latency", 64'(doneAt), 64'd7);
    checkOutput("dump_e1_5", ele1, 64'd5);
    checkOutput("dump_e5_7", ele5, 64'd7);

    // Element isolation: a CPU store to element 3's word leaves ele3 alone
    applyStimulus(1'b1, 10'd16, 64'd99);
    repeat (3) tick();
    checkOutput("iso_ele3_held", ele3, 64'd9);
    runDump(doneAt);
    checkOutput("iso_latency", 64'(doneAt), 64'd7);
    checkOutput("iso_ele3_new", ele3, 64'd99);

    // CPU write then read back, data one cycle after the grant
    applyStimulus(1'b1, 10'd40, 64'hDEAD_BEEF);
    applyStimulus(1'b0, 10'd40, 64'd0);
    @(negedge clk);
    checkOutput("rd_rvalid_timing", 64'(cpu_rvalid), 64'd1);
    checkOutput("rd_data_direct", cpu_rdata, 64'hDEAD_BEEF);
    tick();
    drainCheck();

    // Contention: CPU requests every cycle of a dump, grants alternate CPU first
    doReset();
    pushDumpExpectation();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    cpu_req    = 1'b1;
    cpu_we     = 1'b0;
    cpu_addr   = randAddr(0);
    for (int n = 1; n <= 12; n++) begin
      got = 1'b0;
      @(negedge clk);
      if (n <= 10) checkOutput($sformatf("contend_stall_c%0d", n), 64'(cpu_stall), 64'(n % 2 == 0));
      if (n >= 11) checkOutput($sformatf("contend_done_c%0d", n), 64'(dump_done), 64'(n == 12));
      if (!cpu_stall) begin
        expRd.push_back(refMem[cpu_addr[9:3]]);
        got = 1'b1;
      end
      tick();
      if (got) cpu_addr = randAddr(0);
    end
    cpu_req = 1'b0;
    drainCheck();

    // A second start pulse while busy is ignored
    pushDumpExpectation();
    reads = 0;
    dones = 0;
    dump_start = 1'b1;
    tick();
    for (int n = 1; n <= 12; n++) begin
      dump_start = (n == 1);
      @(negedge clk);
      if (mem_en) reads++;
      if (dump_done) dones++;
      tick();
    end
    dump_start = 1'b0;
    checkOutput("ignored_start_reads", 64'(reads), 64'd5);
    checkOutput("ignored_start_dones", 64'(dones), 64'd1);
    drainCheck();

    // Reset in the third cycle of a dump aborts it
    pushDumpExpectation();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    expDump.delete();
    expRd.delete();
    @(negedge clk);
    checkOutput("midreset_busy", 64'(dump_busy), 64'd0);
    checkOutput("midreset_mem_en", 64'(mem_en), 64'd0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (dump_done) dones++;
      tick();
    end
    checkOutput("midreset_no_done", 64'(dones), 64'd0);
    checkOutput("midreset_busy_after", 64'(dump_busy), 64'd0);
    checkOutput("midreset_ele1", ele1, 64'd0);
    checkOutput("midreset_ele2", ele2, 64'd0);
    checkOutput("midreset_ele5", ele5, 64'd0);
    runDump(doneAt);
    checkOutput("post_reset_latency", 64'(doneAt), 64'd7);

    // Randomised traffic: idle CPU accesses, then dumps with concurrent CPU traffic
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(2, 5)) begin
        applyStimulus(1'($urandom_range(0, 1)), randAddr(0), {$urandom, $urandom});
      end
      fork
        runDump(doneAt);
        begin
          repeat ($urandom_range(1, 4)) begin
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(1'($urandom_range(0, 1)), randAddr(5), {$urandom, $urandom});
          end
        end
      join
      checkOutput($sformatf("rand_dump_finished_r%0d", r), 64'(doneAt > 0), 64'd1);
    end
    drainCheck();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
